// File: rtl/mem_lsu_pkg.sv
// osiris_lsu_pkg: shared LSU state encoding, funct3 access codes and result-source codes.
package osiris_lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;
endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align: byte enables, store-lane replication, load lane extraction/extension and legality check.
module lsu_align
  import osiris_lsu_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        bad
);
  logic       is_b;
  logic       is_h;
  logic       legal;
  logic [7:0] rb;
  logic [15:0] rh;
  always_comb begin
    is_b = funct3[1:0] == 2'b00;
    is_h = funct3[1:0] == 2'b01;
    legal = funct3 == FUNCT3_LB || funct3 == FUNCT3_LH || funct3 == FUNCT3_LW ||
            funct3 == FUNCT3_LBU || funct3 == FUNCT3_LHU;
    bad = !legal || (is_h && addr[0]) || (funct3 == FUNCT3_LW && addr != 2'b00);
    be = is_b ? 4'b0001 << addr : is_h ? 4'b0011 << {addr[1], 1'b0} : 4'hF;
    wdata_rep = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
    rb = rdata[{addr, 3'b000} +: 8];
    rh = rdata[{addr[1], 4'b0000} +: 16];
    // funct3[2] marks the unsigned variants
    rdata_ext = is_b ? {{24{!funct3[2] && rb[7]}}, rb} :
                is_h ? {{16{!funct3[2] && rh[15]}}, rh} : rdata;
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit driving a req/gnt/rvalid data port, stalling until each access completes.
module mem_lsu
  import osiris_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_alu_result_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  input  logic [2:0]            i_funct3_M,
  input  logic [1:0]            i_result_src_M,
  input  logic                  i_mem_write_M,
  output logic                  o_stall_M,
  output logic [DATA_WIDTH-1:0] o_read_data_M,
  output logic                  o_misaligned_M,
  output logic                  o_bus_err_M,
  output logic                  o_dmem_req,
  input  logic                  i_dmem_gnt,
  output logic                  o_dmem_we,
  output logic [DATA_WIDTH-1:0] o_dmem_addr,
  output logic [3:0]            o_dmem_be,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  input  logic                  i_dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  input  logic                  i_dmem_err
);
  localparam int CW = $clog2(TIMEOUT);
  if (DATA_WIDTH != 32 || REG_WIDTH < 1 || TIMEOUT < 2) begin : g_bad_param
    $error("mem_lsu: unsupported parameter set");
  end
  lsu_state_t            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  load;
  logic                  access;
  logic                  bad;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] rdata_ext;
  lsu_align u_align (
    .addr      (i_alu_result_M[1:0]),
    .funct3    (i_funct3_M),
    .wdata     (i_write_data_M),
    .rdata     (i_dmem_rdata),
    .be        (o_dmem_be),
    .wdata_rep (o_dmem_wdata),
    .rdata_ext (rdata_ext),
    .bad       (bad)
  );
  assign o_dmem_addr   = {i_alu_result_M[DATA_WIDTH-1:2], 2'b00};
  assign o_dmem_we     = !load && i_mem_write_M;
  assign o_read_data_M = rdata_q;
  assign o_bus_err_M   = err_q;
  always_comb begin
    load = i_result_src_M == RESULT_SRC_MEM;
    access = load || i_mem_write_M;
    timeout = cnt_q == CW'(TIMEOUT - 1);
    state_d = state_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    err_d = 1'b0;
    o_dmem_req = 1'b0;
    o_stall_M = 1'b0;
    o_misaligned_M = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_misaligned_M = access && bad;
        o_dmem_req = access && !bad;
        o_stall_M = access && !bad;
        cnt_d = '0;
        if (access && !bad) state_d = i_dmem_gnt ? RESP : REQ;
      end
      REQ: begin
        o_dmem_req = 1'b1;
        o_stall_M = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          state_d = DONE;
          err_d = 1'b1;
          rdata_d = '0;
        end else if (i_dmem_gnt) state_d = RESP;
      end
      RESP: begin
        o_stall_M = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (i_dmem_rvalid) begin
          state_d = DONE;
          err_d = i_dmem_err;
          rdata_d = i_dmem_err ? '0 : load ? rdata_ext : rdata_q;
        end else if (timeout) begin
          state_d = DONE;
          err_d = 1'b1;
          rdata_d = '0;
        end
      end
      DONE: state_d = IDLE;
    endcase
    // reset must silence the bus immediately, not only after the next edge
    if (!rst) begin
      o_dmem_req = 1'b0;
      o_stall_M = 1'b0;
      o_misaligned_M = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu with hand-computed expectations.
module tb_mem_lsu;
  logic        clk, rst;
  logic [31:0] alu, wd, rdo, addr, wdo, rdi;
  logic [2:0]  f3;
  logic [1:0]  rsrc;
  logic        mw, stall, mis, berr, req, gnt, we, rvalid, err;
  logic [3:0]  be;
  int          n_cmp = 0;
  int          n_err = 0;
  int          sc;
  mem_lsu dut (
    .clk(clk), .rst(rst), .i_alu_result_M(alu), .i_write_data_M(wd), .i_funct3_M(f3),
    .i_result_src_M(rsrc), .i_mem_write_M(mw), .o_stall_M(stall), .o_read_data_M(rdo),
    .o_misaligned_M(mis), .o_bus_err_M(berr), .o_dmem_req(req), .i_dmem_gnt(gnt),
    .o_dmem_we(we), .o_dmem_addr(addr), .o_dmem_be(be), .o_dmem_wdata(wdo),
    .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdi), .i_dmem_err(err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  // grant in the request cycle, response one cycle later; returns inside DONE
  task automatic quick(input logic [31:0] rd, input logic er);
    gnt = 1'b1;
    #1;
    nxt();
    gnt = 1'b0;
    rvalid = 1'b1;
    rdi = rd;
    err = er;
    #1;
    nxt();
    rvalid = 1'b0;
    err = 1'b0;
    #1;
  endtask
  initial begin
    rst = 1'b0; alu = 32'h100; wd = 32'hDEADBEEF; f3 = 3'b010; rsrc = 2'b00; mw = 1'b1;
    gnt = 1'b1; rvalid = 1'b0; rdi = '0; err = 1'b0;
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata", rdo, 32'd0);
    chk("rst_mis", 32'(mis), 32'd0);
    chk("rst_berr", 32'(berr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; mw = 1'b0; gnt = 1'b0;
    nxt();
    mw = 1'b1; alu = 32'h100; wd = 32'hDEADBEEF; f3 = 3'b010; gnt = 1'b1;
    #1;
    chk("sw_req", 32'(req), 32'd1);
    chk("sw_stall0", 32'(stall), 32'd1);
    chk("sw_we", 32'(we), 32'd1);
    chk("sw_be", 32'(be), 32'hF);
    chk("sw_wdata", wdo, 32'hDEADBEEF);
    chk("sw_addr", addr, 32'h100);
    nxt();
    gnt = 1'b0; rvalid = 1'b1;
    #1;
    chk("sw_resp_req", 32'(req), 32'd0);
    chk("sw_stall1", 32'(stall), 32'd1);
    nxt();
    rvalid = 1'b0;
    #1;
    chk("sw_done_stall", 32'(stall), 32'd0);
    chk("sw_berr", 32'(berr), 32'd0);
    chk("sw_rdata_kept", rdo, 32'd0);
    nxt();
    mw = 1'b0; rsrc = 2'b01; f3 = 3'b000; alu = 32'h103;
    #1;
    chk("lb_be", 32'(be), 32'h8);
    chk("lb_we", 32'(we), 32'd0);
    chk("lb_addr", addr, 32'h100);
    quick(32'h80FF_0000, 1'b0);
    chk("lb_data", rdo, 32'hFFFFFF80);
    chk("lb_done_stall", 32'(stall), 32'd0);
    nxt();
    f3 = 3'b100;
    quick(32'h80FF_0000, 1'b0);
    chk("lbu_data", rdo, 32'h00000080);
    nxt();
    f3 = 3'b001; alu = 32'h102;
    quick(32'h8001_0000, 1'b0);
    chk("lh_data", rdo, 32'hFFFF8001);
    nxt();
    f3 = 3'b101;
    quick(32'h8001_0000, 1'b0);
    chk("lhu_data", rdo, 32'h00008001);
    nxt();
    rsrc = 2'b00; mw = 1'b1; f3 = 3'b001; alu = 32'h102; wd = 32'h1234BEEF;
    #1;
    chk("sh_be", 32'(be), 32'hC);
    chk("sh_wdata", wdo, 32'hBEEFBEEF);
    quick(32'h0, 1'b1);
    chk("sh_err_berr", 32'(berr), 32'd1);
    chk("sh_err_rdata", rdo, 32'd0);
    nxt();
    mw = 1'b0;
    #1;
    chk("berr_pulse", 32'(berr), 32'd0);
    rsrc = 2'b01; f3 = 3'b001; alu = 32'h101;
    #1;
    chk("lh_mis", 32'(mis), 32'd1);
    chk("lh_mis_req", 32'(req), 32'd0);
    chk("lh_mis_stall", 32'(stall), 32'd0);
    nxt();
    f3 = 3'b011; alu = 32'h100;
    #1;
    chk("f3_011_mis", 32'(mis), 32'd1);
    chk("f3_011_req", 32'(req), 32'd0);
    chk("f3_011_stall", 32'(stall), 32'd0);
    nxt();
    rsrc = 2'b00;
    #1;
    chk("mis_clear", 32'(mis), 32'd0);
    nxt();
    rsrc = 2'b01; f3 = 3'b010; alu = 32'h104; rdi = 32'h12345678; sc = 0;
    for (int c = 0; c < 7; c++) begin
      gnt = (c == 3);
      rvalid = (c == 5);
      #1;
      sc += int'(stall);
      if (c == 2) chk("lw_req_held", 32'(req), 32'd1);
      if (c == 4) chk("lw_resp_req", 32'(req), 32'd0);
      if (c < 6) nxt();
    end
    chk("lw_stall_cycles", sc, 32'd6);
    chk("lw_data", rdo, 32'h12345678);
    nxt();
    alu = 32'h108; sc = 0;
    for (int c = 0; c < 18; c++) begin
      gnt = (c == 0);
      #1;
      sc += int'(stall);
      if (c == 16) chk("to_berr_early", 32'(berr), 32'd0);
      if (c < 17) nxt();
    end
    chk("to_stall_cycles", sc, 32'd17);
    chk("to_berr", 32'(berr), 32'd1);
    chk("to_rdata", rdo, 32'd0);
    nxt();
    rsrc = 2'b00;
    #1;
    chk("to_idle_berr", 32'(berr), 32'd0);
    chk("to_idle_req", 32'(req), 32'd0);
    rsrc = 2'b01; alu = 32'h10C; gnt = 1'b1;
    #1;
    nxt();
    gnt = 1'b0;
    #1;
    chk("rr_resp_stall", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("rr_req", 32'(req), 32'd0);
    chk("rr_stall", 32'(stall), 32'd0);
    nxt();
    rst = 1'b1; rsrc = 2'b00; rvalid = 1'b1; rdi = 32'hCAFEBABE;
    #1;
    chk("rr_late_stall", 32'(stall), 32'd0);
    nxt();
    rvalid = 1'b0;
    #1;
    chk("rr_late_berr", 32'(berr), 32'd0);
    mw = 1'b1; f3 = 3'b000; alu = 32'h101; wd = 32'h0000005A;
    #1;
    chk("sb_be", 32'(be), 32'h2);
    chk("sb_wdata", wdo, 32'h5A5A5A5A);
    chk("sb_req", 32'(req), 32'd1);
    quick(32'h0, 1'b0);
    chk("sb_done_stall", 32'(stall), 32'd0);
    chk("sb_berr", 32'(berr), 32'd0);
    nxt();
    mw = 1'b0;
    #1;
    chk("sb_idle_req", 32'(req), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
